fetch_sequencer: RTL and testbench

Instruction-fetch controller that owns the program counter and sequences reads from the synchronous instruction ROM. It presents each fetched word to decode over a valid/ready handshake and redirects the PC on branches, flushing any in-flight read. It stops on a HALT opcode. It sits between the ROM and the decode/execute stage and replaces free-running PC/ROM operation with a controlled, stallable fetch.

---
 rtl/fetch_sequencer.sv | 142 ++++++++++++++
 tb/tb_fetch_sequencer.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, issues one ROM read at a time,
// presents the captured word over valid/ready, and handles branches and HALT.
module fetch_sequencer #(
  parameter int unsigned          ADDR_W   = 16,
  parameter int unsigned          DATA_W   = 16,
  parameter int unsigned          ROM_LAT  = 1,
  parameter logic [ADDR_W-1:0]    RESET_PC = '0,
  parameter logic [3:0]           HALT_OPC = 4'hF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] instr_out,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              branch_valid,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              busy,
  output logic              halted,
  output logic [15:0]       fetch_cnt,
  output logic [2:0]        dbg_state
);

  // Handshake: a word transfers on a rising edge where instr_valid and
  // instr_ready are both high; instr_out/instr_pc are held while valid waits.

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_WAIT    = 3'd2,
    S_PRESENT = 3'd3,
    S_HALT    = 3'd4
  } state_t;

  localparam int unsigned CNT_W = 2;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  instr_q, instr_d;
  logic [ADDR_W-1:0]  ipc_q, ipc_d;
  logic               valid_q, valid_d;
  logic [15:0]        fcnt_q, fcnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      cnt_q   <= '0;
      instr_q <= '0;
      ipc_q   <= '0;
      valid_q <= 1'b0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      valid_q <= valid_d;
      fcnt_q  <= fcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    valid_d = valid_q;
    fcnt_d  = fcnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (branch_valid) begin
          pc_d = branch_target;
        end else begin
          cnt_d   = CNT_W'(ROM_LAT);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (branch_valid) begin
          // The in-flight read is simply never captured.
          pc_d    = branch_target;
          cnt_d   = '0;
          state_d = S_ISSUE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_d == '0) begin
            instr_d = rom_data;
            ipc_d   = pc_q;
            valid_d = 1'b1;
            state_d = S_PRESENT;
          end
        end
      end
      S_PRESENT: begin
        if (instr_ready) begin
          valid_d = 1'b0;
          if (fcnt_q != 16'hFFFF) fcnt_d = fcnt_q + 16'd1;
          if (instr_q[DATA_W-1 -: 4] == HALT_OPC) begin
            state_d = S_HALT;
          end else if (branch_valid) begin
            pc_d    = branch_target;
            state_d = S_ISSUE;
          end else begin
            pc_d    = pc_q + ADDR_W'(1);
            state_d = S_ISSUE;
          end
        end else if (branch_valid) begin
          valid_d = 1'b0;
          pc_d    = branch_target;
          state_d = S_ISSUE;
        end
      end
      S_HALT: begin
        if (start) begin
          pc_d    = RESET_PC;
          state_d = S_ISSUE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign rom_addr    = pc_q;
  assign instr_out   = instr_q;
  assign instr_pc    = ipc_q;
  assign instr_valid = valid_q;
  assign busy        = (state_q == S_ISSUE) || (state_q == S_WAIT) || (state_q == S_PRESENT);
  assign halted      = (state_q == S_HALT);
  assign fetch_cnt   = fcnt_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: three instances (ROM_LAT=1, ROM_LAT=3, RESET_PC=FFFF)
// each fed by a ROM model whose output lags the address by ROM_LAT clocks.
module tb_fetch_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  logic        start_a, ready_a, bv_a, start_b, ready_b, bv_b, start_c, ready_c, bv_c;
  logic [15:0] bt_a, bt_b, bt_c;
  logic [15:0] addr_a, data_a, instr_a, ipc_a, cnt_a;
  logic [15:0] addr_b, data_b, instr_b, ipc_b, cnt_b;
  logic [15:0] addr_c, data_c, instr_c, ipc_c, cnt_c;
  logic        valid_a, busy_a, halted_a, valid_b, busy_b, halted_b, valid_c, busy_c, halted_c;
  logic [2:0]  st_a, st_b, st_c;

  logic [31:0] exp_q[$];

  function automatic logic [15:0] rom_a(input logic [15:0] a);
    case (a)
      16'h0000: return 16'h1111;
      16'h0001: return 16'h2222;
      16'h0002: return 16'h3333;
      16'h0003: return 16'hF000;
      16'h0040: return 16'h4444;
      default:  return {4'h1, a[11:0]};
    endcase
  endfunction

  function automatic logic [15:0] rom_b(input logic [15:0] a);
    return {4'h2, a[11:0]};
  endfunction

  function automatic logic [15:0] rom_c(input logic [15:0] a);
    case (a)
      16'hFFFF: return 16'h1234;
      16'h0000: return 16'h5678;
      16'h0001: return 16'hF000;
      default:  return {4'h3, a[11:0]};
    endcase
  endfunction

  logic [15:0] pipe_a, pipe_c;
  logic [15:0] pipe_b [3];
  always @(posedge clk) begin
    pipe_a    <= rom_a(addr_a);
    pipe_c    <= rom_c(addr_c);
    pipe_b[0] <= rom_b(addr_b);
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
  end
  assign data_a = pipe_a;
  assign data_b = pipe_b[2];
  assign data_c = pipe_c;

  fetch_sequencer #(.ROM_LAT(1), .RESET_PC(16'h0000)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .rom_addr(addr_a), .rom_data(data_a),
    .instr_out(instr_a), .instr_pc(ipc_a), .instr_valid(valid_a), .instr_ready(ready_a),
    .branch_valid(bv_a), .branch_target(bt_a), .busy(busy_a), .halted(halted_a),
    .fetch_cnt(cnt_a), .dbg_state(st_a));

  fetch_sequencer #(.ROM_LAT(3), .RESET_PC(16'h0000)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .rom_addr(addr_b), .rom_data(data_b),
    .instr_out(instr_b), .instr_pc(ipc_b), .instr_valid(valid_b), .instr_ready(ready_b),
    .branch_valid(bv_b), .branch_target(bt_b), .busy(busy_b), .halted(halted_b),
    .fetch_cnt(cnt_b), .dbg_state(st_b));

  fetch_sequencer #(.ROM_LAT(1), .RESET_PC(16'hFFFF)) dut_c (
    .clk(clk), .rst(rst), .start(start_c), .rom_addr(addr_c), .rom_data(data_c),
    .instr_out(instr_c), .instr_pc(ipc_c), .instr_valid(valid_c), .instr_ready(ready_c),
    .branch_valid(bv_c), .branch_target(bt_c), .busy(busy_c), .halted(halted_c),
    .fetch_cnt(cnt_c), .dbg_state(st_c));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard on DUT A: every accepted {pc, word} must match the expected queue.
  always @(negedge clk) begin
    if (!rst && valid_a && ready_a) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_unexpected: got %h_%h expected nothing", ipc_a, instr_a);
      end else begin
        chk("sb_accept", {ipc_a, instr_a}, exp_q.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        start;
    logic        ready;
    logic        bv;
    logic [15:0] bt;
    logic        valid;
    logic [15:0] instr;
    logic [15:0] pc;
    logic [15:0] addr;
    logic [15:0] cnt;
    logic        busy;
    logic        halted;
  } vec_t;

  vec_t vec [14];

  initial begin
    // start, ready, bv, bt, valid, instr, pc, addr, cnt, busy, halted
    vec[0]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'd0, 1'b1, 1'b0};
    vec[1]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'd0, 1'b1, 1'b0};
    vec[2]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h1111, 16'h0000, 16'h0000, 16'd0, 1'b1, 1'b0};
    vec[3]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 16'h0001, 16'd1, 1'b1, 1'b0};
    vec[4]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 16'h0001, 16'd1, 1'b1, 1'b0};
    vec[5]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h2222, 16'h0001, 16'h0001, 16'd1, 1'b1, 1'b0};
    vec[6]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 16'h0002, 16'd2, 1'b1, 1'b0};
    vec[7]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 16'h0002, 16'd2, 1'b1, 1'b0};
    vec[8]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h3333, 16'h0002, 16'h0002, 16'd2, 1'b1, 1'b0};
    vec[9]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 16'h0003, 16'd3, 1'b1, 1'b0};
    vec[10] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 16'h0003, 16'd3, 1'b1, 1'b0};
    vec[11] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'hF000, 16'h0003, 16'h0003, 16'd3, 1'b1, 1'b0};
    vec[12] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 16'h0003, 16'd4, 1'b0, 1'b1};
    vec[13] = '{1'b0, 1'b1, 1'b1, 16'h0040, 1'b0, 16'h0000, 16'h0000, 16'h0003, 16'd4, 1'b0, 1'b1};

    rst = 1'b1;
    start_a = 0; ready_a = 0; bv_a = 0; bt_a = '0;
    start_b = 0; ready_b = 0; bv_b = 0; bt_b = '0;
    start_c = 0; ready_c = 0; bv_c = 0; bt_c = '0;
    tick();
    tick();

    chk("rst_a_state", st_a, 3'd0);
    chk("rst_a_valid", valid_a, 1'b0);
    chk("rst_a_addr", addr_a, 16'h0000);
    chk("rst_a_instr", instr_a, 16'h0000);
    chk("rst_a_ipc", ipc_a, 16'h0000);
    chk("rst_a_cnt", cnt_a, 16'd0);
    chk("rst_a_busy", busy_a, 1'b0);
    chk("rst_a_halted", halted_a, 1'b0);
    chk("rst_b_state", st_b, 3'd0);
    chk("rst_c_state", st_c, 3'd0);
    chk("rst_c_addr", addr_c, 16'hFFFF);
    rst = 1'b0;

    // Main fetch run to HALT, one record per clock.
    exp_q.push_back({16'h0000, 16'h1111});
    exp_q.push_back({16'h0001, 16'h2222});
    exp_q.push_back({16'h0002, 16'h3333});
    exp_q.push_back({16'h0003, 16'hF000});
    for (int i = 0; i < 14; i++) begin
      start_a = vec[i].start; ready_a = vec[i].ready; bv_a = vec[i].bv; bt_a = vec[i].bt;
      tick();
      chk($sformatf("vec%0d_valid", i), valid_a, vec[i].valid);
      if (vec[i].valid) begin
        chk($sformatf("vec%0d_instr", i), instr_a, vec[i].instr);
        chk($sformatf("vec%0d_pc", i), ipc_a, vec[i].pc);
      end
      chk($sformatf("vec%0d_addr", i), addr_a, vec[i].addr);
      chk($sformatf("vec%0d_cnt", i), cnt_a, vec[i].cnt);
      chk($sformatf("vec%0d_busy", i), busy_a, vec[i].busy);
      chk($sformatf("vec%0d_halted", i), halted_a, vec[i].halted);
    end
    start_a = 0; ready_a = 0; bv_a = 0; bt_a = '0;

    // Reset out of HALT.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_halt_state", st_a, 3'd0);
    chk("rst_halt_halted", halted_a, 1'b0);
    chk("rst_halt_cnt", cnt_a, 16'd0);

    // Backpressure on the first word.
    start_a = 1; tick(); start_a = 0;
    tick();
    tick();
    chk("bp_first_valid", valid_a, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("bp%0d_valid", i), valid_a, 1'b1);
      chk($sformatf("bp%0d_instr", i), instr_a, 16'h1111);
      chk($sformatf("bp%0d_pc", i), ipc_a, 16'h0000);
      chk($sformatf("bp%0d_addr", i), addr_a, 16'h0000);
      chk($sformatf("bp%0d_cnt", i), cnt_a, 16'd0);
    end
    exp_q.push_back({16'h0000, 16'h1111});
    ready_a = 1; tick(); ready_a = 0;
    chk("bp_accept_cnt", cnt_a, 16'd1);
    chk("bp_accept_addr", addr_a, 16'h0001);

    // Branch taken on the handshake at PC=1.
    tick();
    tick();
    chk("bh_valid", valid_a, 1'b1);
    chk("bh_pc", ipc_a, 16'h0001);
    exp_q.push_back({16'h0001, 16'h2222});
    ready_a = 1; bv_a = 1; bt_a = 16'h0040; tick();
    ready_a = 0; bv_a = 0;
    chk("bh_addr", addr_a, 16'h0040);
    chk("bh_cnt", cnt_a, 16'd2);
    tick();
    chk("bh_gap_valid", valid_a, 1'b0);
    tick();
    chk("bh_next_valid", valid_a, 1'b1);
    chk("bh_next_pc", ipc_a, 16'h0040);
    chk("bh_next_instr", instr_a, 16'h4444);

    // Branch in PRESENT without a handshake discards the word.
    bv_a = 1; bt_a = 16'h0002; tick(); bv_a = 0;
    chk("bp_br_valid", valid_a, 1'b0);
    chk("bp_br_cnt", cnt_a, 16'd2);
    chk("bp_br_addr", addr_a, 16'h0002);
    tick();
    tick();
    chk("bp_br_next_pc", ipc_a, 16'h0002);
    chk("bp_br_next_instr", instr_a, 16'h3333);

    // Reset while presenting.
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst_present_state", st_a, 3'd0);
    chk("rst_present_valid", valid_a, 1'b0);
    chk("rst_present_addr", addr_a, 16'h0000);
    chk("rst_present_cnt", cnt_a, 16'd0);

    // Reset while waiting on the ROM, then a clean restart.
    start_a = 1; tick(); start_a = 0;
    tick();
    chk("pre_rst_wait_state", st_a, 3'd2);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst_wait_state", st_a, 3'd0);
    chk("rst_wait_valid", valid_a, 1'b0);
    chk("rst_wait_addr", addr_a, 16'h0000);
    tick();
    chk("rst_wait_idle_valid", valid_a, 1'b0);
    start_a = 1; tick(); start_a = 0;
    tick();
    tick();
    chk("restart_valid", valid_a, 1'b1);
    chk("restart_pc", ipc_a, 16'h0000);
    exp_q.push_back({16'h0000, 16'h1111});
    ready_a = 1; tick(); ready_a = 0;
    chk("restart_cnt", cnt_a, 16'd1);

    // DUT B (ROM_LAT=3): branch while a read is in flight.
    start_b = 1; tick(); start_b = 0;
    tick();
    chk("bw_state_wait", st_b, 3'd2);
    bv_b = 1; bt_b = 16'h0010; tick(); bv_b = 0;
    chk("bw_br_valid", valid_b, 1'b0);
    chk("bw_br_addr", addr_b, 16'h0010);
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk($sformatf("bw_gap%0d_valid", i), valid_b, 1'b0);
    end
    tick();
    chk("bw_next_valid", valid_b, 1'b1);
    chk("bw_next_pc", ipc_b, 16'h0010);
    chk("bw_next_instr", instr_b, 16'h2010);
    ready_b = 1; tick(); ready_b = 0;
    chk("bw_accept_cnt", cnt_b, 16'd1);
    chk("bw_accept_addr", addr_b, 16'h0011);

    // DUT C (RESET_PC=FFFF): PC wraps to zero, then HALT and restart.
    start_c = 1; tick(); start_c = 0;
    ready_c = 1;
    tick();
    tick();
    chk("wrap_first_valid", valid_c, 1'b1);
    chk("wrap_first_pc", ipc_c, 16'hFFFF);
    chk("wrap_first_instr", instr_c, 16'h1234);
    tick();
    chk("wrap_addr", addr_c, 16'h0000);
    tick();
    tick();
    chk("wrap_second_valid", valid_c, 1'b1);
    chk("wrap_second_pc", ipc_c, 16'h0000);
    chk("wrap_second_instr", instr_c, 16'h5678);
    tick();
    tick();
    tick();
    chk("wrap_halt_word", instr_c, 16'hF000);
    tick();
    ready_c = 0;
    chk("wrap_halted", halted_c, 1'b1);
    chk("wrap_halt_cnt", cnt_c, 16'd3);
    chk("wrap_halt_addr", addr_c, 16'h0001);
    start_c = 1; tick(); start_c = 0;
    chk("halt_restart_addr", addr_c, 16'hFFFF);
    chk("halt_restart_busy", busy_c, 1'b1);
    chk("halt_restart_cnt", cnt_c, 16'd3);

    chk("sb_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
